// File: rtl/mem_init_seq.sv
// mem_init_seq: fills DEPTH words of a single-port RAM with a selectable pattern.
// First user is the RC4 S-array init (S[i] = i); grant lets it share the RAM
// write port with downstream FSMs.
//
// Ports:
//   clk        - system clock, all state changes on rising edge
//   reset      - synchronous active-low reset
//   start      - fill request, honoured only in IDLE
//   mode       - fill pattern (0 identity, 1 constant, 2 descending, 3 i^fill_value)
//   fill_value - pattern operand, latched with mode on accepted start
//   grant      - RAM port granted this cycle; writes only happen while high
//   address    - registered RAM write address
//   data       - registered RAM write data
//   wren       - RAM write enable (WRITE state and grant)
//   busy       - high while in WRITE
//   done       - one-cycle pulse after the final write
//   complete   - level from done until the next accepted start or reset
module mem_init_seq #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              grant,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic              complete
);

    // Elaboration-time parameter legality check.
    generate
        if (DEPTH < 1 || ADDR_W < 1 || ADDR_W > 31 || DATA_W < 1 || DATA_W > 32 ||
            64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_param
            $error("mem_init_seq: illegal ADDR_W/DATA_W/DEPTH combination");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [1:0]        mode_lat;
    logic [DATA_W-1:0] fill_lat;

    // Word value for index i; arithmetic done at 32 bits then truncated.
    function automatic logic [DATA_W-1:0] pattern(
        input logic [ADDR_W-1:0] i,
        input logic [1:0]        m,
        input logic [DATA_W-1:0] fv
    );
        logic [31:0] iw;
        iw = 32'(i);
        case (m)
            2'd0:    pattern = DATA_W'(iw);
            2'd1:    pattern = fv;
            2'd2:    pattern = DATA_W'(32'(DEPTH - 1) - iw);
            default: pattern = DATA_W'(iw) ^ fv;
        endcase
    endfunction

    // Write strobe follows grant directly so a denied cycle never writes.
    assign wren = (state == WRITE) && grant;

    // Sequencer state, index and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            index    <= '0;
            address  <= '0;
            data     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            complete <= 1'b0;
            mode_lat <= 2'd0;
            fill_lat <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_lat <= mode;
                        fill_lat <= fill_value;
                        index    <= '0;
                        address  <= '0;
                        data     <= pattern('0, mode, fill_value);
                        complete <= 1'b0;
                        busy     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    // No grant: hold everything so no word is skipped or repeated.
                    if (grant) begin
                        if (index == LAST) begin
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            complete <= 1'b1;
                            state    <= DONE;
                        end else begin
                            index   <= index + ADDR_W'(1);
                            address <= index + ADDR_W'(1);
                            data    <= pattern(index + ADDR_W'(1), mode_lat, fill_lat);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
